// File: rtl/csi_raw_unpacker.sv
// CSI-2 RAW8/RAW10/RAW12 byte-stream unpacker: regroups IN_BYTES-wide beats into
// words of four zero-extended pixels, with line-end residue checking and word counting.
module csi_raw_unpacker #(
    parameter int IN_BYTES       = 2,
    parameter int PIXEL_WIDTH    = 16,
    parameter int LINE_CNT_WIDTH = 16
) (
    input  logic                      rxbyteclkhs,
    input  logic                      reset,
    input  logic                      frame_active,
    input  logic [1:0]                mode,
    input  logic                      in_valid,
    input  logic [8*IN_BYTES-1:0]     data_in,
    input  logic                      line_end,
    output logic [4*PIXEL_WIDTH-1:0]  data_out,
    output logic                      out_valid,
    output logic                      err_partial,
    output logic [LINE_CNT_WIDTH-1:0] line_words
);
    localparam int BUF = 5 + IN_BYTES;
    localparam int CW  = $clog2(BUF + 1);

    typedef enum logic [1:0] {RAW8 = 2'b00, RAW10 = 2'b01, RAW12 = 2'b10, RSVD = 2'b11} mode_e;

    logic [BUF-1:0][7:0]             buf_q, cat, shifted;
    logic [BUF+5:0][7:0]             cat_ext;
    logic [CW-1:0]                   cnt_q, total, grp, rest_cnt;
    logic [LINE_CNT_WIDTH-1:0]       wcnt_q, wcnt_d, line_words_q;
    logic [3:0][PIXEL_WIDTH-1:0]     word_d, word_q;
    logic                            act_q, out_valid_q, err_q;
    logic                            take, emit;
    mode_e                           mode_q, mode_eff;

    assign data_out    = word_q;
    assign out_valid   = out_valid_q;
    assign err_partial = err_q;
    assign line_words  = line_words_q;

    always_comb begin
        // The first active cycle of a frame already decodes with the mode being latched.
        mode_eff = act_q ? mode_q : mode_e'(mode);
        case (mode_eff)
            RAW8:    grp = CW'(4);
            RAW10:   grp = CW'(5);
            default: grp = CW'(6);
        endcase
        take = frame_active && in_valid && (mode_eff != RSVD);

        cat = buf_q;
        for (int k = 0; k < BUF; k++)
            for (int j = 0; j < IN_BYTES; j++)
                if (take && (k == int'(cnt_q) + j))
                    cat[k] = data_in[8*(IN_BYTES-1-j) +: 8];

        total    = cnt_q + (take ? CW'(IN_BYTES) : '0);
        emit     = frame_active && (mode_eff != RSVD) && (total >= grp);
        rest_cnt = emit ? total - grp : total;

        cat_ext = {48'h0, cat};
        shifted = '0;
        for (int k = 0; k < BUF; k++)
            for (int s = 4; s <= 6; s++)
                if (int'(grp) == s)
                    shifted[k] = cat_ext[k+s];

        word_d = '0;
        case (mode_eff)
            RAW8: begin
                for (int i = 0; i < 4; i++)
                    word_d[i] = PIXEL_WIDTH'(cat[i]);
            end
            RAW10: begin
                for (int i = 0; i < 4; i++)
                    word_d[i] = PIXEL_WIDTH'({cat[i], cat[4][2*i +: 2]});
            end
            default: begin
                word_d[0] = PIXEL_WIDTH'({cat[0], cat[2][3:0]});
                word_d[1] = PIXEL_WIDTH'({cat[1], cat[2][7:4]});
                word_d[2] = PIXEL_WIDTH'({cat[3], cat[5][3:0]});
                word_d[3] = PIXEL_WIDTH'({cat[4], cat[5][7:4]});
            end
        endcase

        wcnt_d = wcnt_q;
        if (emit && !(&wcnt_q))
            wcnt_d = wcnt_q + 1'b1;
    end

    always_ff @(posedge rxbyteclkhs or posedge reset) begin
        if (reset) begin
            buf_q        <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            mode_q       <= RAW8;
            act_q        <= 1'b0;
            word_q       <= '0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            line_words_q <= '0;
        end else if (!frame_active) begin
            // Frame abort: same as reset but the last line count stays visible.
            buf_q       <= '0;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            mode_q      <= RAW8;
            act_q       <= 1'b0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            act_q       <= 1'b1;
            mode_q      <= mode_eff;
            out_valid_q <= emit;
            if (emit)
                word_q <= word_d;
            if (line_end) begin
                buf_q        <= '0;
                cnt_q        <= '0;
                err_q        <= (rest_cnt != '0);
                line_words_q <= wcnt_d;
                wcnt_q       <= '0;
            end else begin
                buf_q  <= emit ? shifted : cat;
                cnt_q  <= rest_cnt;
                err_q  <= 1'b0;
                wcnt_q <= wcnt_d;
            end
        end
    end
endmodule

// File: doc/csi_raw_unpacker.md
Name: csi_raw_unpacker

Overview:
- Parametrised successor to the fixed RAW10/16-bit decoder.
- Unpacks CSI-2 RAW8, RAW10 and RAW12 byte streams into words of four zero-extended pixels.
- Input byte width is parametrised at 2 or 4 bytes per beat.
- Sits between the lane merger / packet parser and the pixel pipeline, in the rxbyteclkhs domain; adds line-end residue checking and per-line word counting.

Parameters:
- IN_BYTES, 2, bytes per input beat; legal values 2 or 4.
- PIXEL_WIDTH, 16, bits per output pixel; must be >= 12.
- LINE_CNT_WIDTH, 16, width of the per-line word counter.

Ports:
- rxbyteclkhs  input  1  byte clock; only clock.
- reset  input  1  asynchronous, active-high reset.
- frame_active  input  1  level; low clears the block.
- mode  input  2  00=RAW8, 01=RAW10, 10=RAW12, 11=reserved.
- in_valid  input  1  data_in beat qualifier.
- data_in  input  8*IN_BYTES  bytes; MSB byte is first in stream order.
- line_end  input  1  pulse marking the last beat of a line.
- data_out  output  4*PIXEL_WIDTH  {pixel3, pixel2, pixel1, pixel0}.
- out_valid  output  1  one-cycle pulse per output word.
- err_partial  output  1  pulse: line ended with residual bytes.
- line_words  output  LINE_CNT_WIDTH  words emitted in the last completed line.

Behaviour:
- Reset: data_out=0, out_valid=0, err_partial=0, line_words=0. Byte buffer, byte count, word counter and latched mode all clear.
- Reset mid-stream drops all buffered bytes.
- frame_active low: same clearing as reset except line_words, which holds its value. No err_partial.
- Mode latch: mode is sampled on the first cycle frame_active is high. Changes of mode while frame_active stays high are ignored.
- Byte buffer: capacity 5+IN_BYTES bytes. Each in_valid beat appends IN_BYTES bytes in stream order (data_in[8*IN_BYTES-1 -: 8] first).
- Group size G: RAW8=4, RAW10=5, RAW12=6 bytes per output word.
- Emission: when bytes held plus bytes arriving >= G, the first G bytes form one word and are removed.
  - At most one word per cycle, since IN_BYTES <= G.
  - Leftover bytes shift to the buffer head.
- Latency: out_valid asserts on the cycle after the beat that completes a group. data_out is registered and holds its last value otherwise; only out_valid qualifies it.
- Throughput: RAW8 with IN_BYTES=4 gives one word per beat, back-to-back.
- Pixel packing for bytes B0..B(G-1); all pixels are zero-extended to PIXEL_WIDTH, right-justified:
  - RAW8: Pi = B_i.
  - RAW10: Pi = {B_i, B4[2i+1:2i]}.
  - RAW12: P0={B0,B2[3:0]}, P1={B1,B2[7:4]}, P2={B3,B5[3:0]}, P3={B4,B5[7:4]}.
- line_end handling (taking effect the cycle after line_end is sampled):
  - When line_end coincides with in_valid, the beat is processed first, including any emission.
  - Residue check: if bytes remain after that beat, err_partial pulses one cycle with the final word's out_valid, and the residue is discarded.
  - line_words is loaded with the line's word count, including a word emitted on the line_end beat. The counter then clears.
  - line_end with an empty buffer gives no error; line_words still updates.
- Word counter saturates at all-ones.
- Reserved mode: beats are discarded; out_valid and err_partial stay 0; line_words reports 0.
- in_valid low cycles insert bubbles only; buffer contents are preserved.

Test Plan:
- RAW10, IN_BYTES=2:
  - Stimulus: beats 0x1122, 0x3344, 0xE455, 0x6677, 0x881B, then line_end.
  - Word 1 the cycle after beat 3: data_out = {0x0113,0x00CE,0x0089,0x0044}.
  - Word 2 the cycle after beat 5: {0x0220,0x01DD,0x019A,0x0157}.
  - line_words = 2, no err_partial.
- RAW12, IN_BYTES=2:
  - Stimulus: beats 0xABCD, 0x2112, 0x3465.
  - One word the cycle after beat 3: {0x0346,0x0125,0x0CD2,0x0AB1}.
- RAW8, IN_BYTES=4:
  - Stimulus: beats 0x01020304 and 0x05060708 on consecutive cycles.
  - Required response: out_valid high two consecutive cycles, words {0x0004,0x0003,0x0002,0x0001} then {0x0008,0x0007,0x0006,0x0005}.
- RAW10 partial line:
  - Stimulus: beats 0x1122, 0x3344, 0xE455, with line_end on the third beat.
  - The cycle after: word {0x0113,0x00CE,0x0089,0x0044}, err_partial=1 and line_words=1.
  - The next line starts from an empty buffer.
- Abort and mode latch:
  - Stimulus: RAW10 with two beats buffered, then frame_active drops for one cycle; in a new frame, mode is changed after the first cycle.
  - Required response: no output and no err_partial; the original mode stays in use.
- Async reset asserted mid-group between clock edges:
  - Required response: outputs are 0 immediately, without waiting for a clock edge; after release, a fresh RAW10 sequence decodes exactly as in scenario 1.
